// File: rtl/syn_lb_reg_slave_if.sv
// syn_lb_reg_slave_if.sv: local-bus read/write bundle between a host master
// and a register slave endpoint.
interface syn_lb_reg_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              lb_rd_en;
    logic              lb_wr_en;
    logic [ADDR_W-1:0] lb_addr;
    logic              lb_wr_valid;
    logic [DATA_W-1:0] lb_wr_data;
    logic              lb_rd_valid;
    logic [DATA_W-1:0] lb_rd_data;

    modport master (
        output lb_rd_en, lb_wr_en, lb_addr, lb_wr_valid, lb_wr_data,
        input  lb_rd_valid, lb_rd_data
    );

    modport slave (
        input  lb_rd_en, lb_wr_en, lb_addr, lb_wr_valid, lb_wr_data,
        output lb_rd_valid, lb_rd_data
    );
endinterface

// File: rtl/syn_lb_reg_slave.sv
// syn_lb_reg_slave.sv: local-bus slave serving RW control and RO status registers.
// Define SYN_LB_SLAVE_ERR_EN for a sticky error register and 0xDEADBEEF unmapped reads.
module syn_lb_reg_slave #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                NUM_CTRL = 4,
    parameter int                NUM_STAT = 4,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
    input  logic                       clk_ir,
    input  logic                       rst_il,
    syn_lb_reg_slave_if.slave          lb,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_regs_o,
    output logic [NUM_CTRL-1:0]        ctrl_wr_o,
    input  logic [NUM_STAT*DATA_W-1:0] stat_regs_i,
    output logic                       busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t              state, state_n;
    logic [2:0]          cnt, cnt_n;
    logic [ADDR_W-1:0]   raddr, raddr_n;
    logic [DATA_W-1:0]   ctrl_q [NUM_CTRL];
    logic [NUM_CTRL-1:0] wr_hit;
    logic                wr_go;
    logic                valid_n;
    logic                busy_n;
    logic [DATA_W-1:0]   rsp_data;
    logic [DATA_W-1:0]   data_n;

`ifdef SYN_LB_SLAVE_ERR_EN
    localparam int                MAP_N      = NUM_CTRL + NUM_STAT + 1;
    localparam logic [ADDR_W-1:0] ERR_ADDR   = ADDR_W'(NUM_CTRL + NUM_STAT);
    localparam logic [DATA_W-1:0] UNMAP_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [2:0] err, err_n;
    logic       rd_go;
    logic       rd_drop;

    function automatic logic unmapped(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= (ADDR_W+1)'(MAP_N);
    endfunction

    assign rd_go   = lb.lb_rd_en && (state == IDLE);
    assign rd_drop = lb.lb_rd_en && (state != IDLE);

    // A new event in the clearing cycle must survive the read-to-clear.
    always_comb begin
        err_n = err;
        if (state == RESP && raddr == ERR_ADDR)
            err_n = '0;
        if (wr_go && unmapped(lb.lb_addr))
            err_n[0] = 1'b1;
        if (rd_go && unmapped(lb.lb_addr))
            err_n[1] = 1'b1;
        if (rd_drop)
            err_n[2] = 1'b1;
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il)
            err <= '0;
        else
            err <= err_n;
    end
`else
    localparam logic [DATA_W-1:0] UNMAP_DATA = '0;
`endif

    assign wr_go = lb.lb_wr_en & lb.lb_wr_valid;

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CTRL; i++)
            wr_hit[i] = wr_go && (lb.lb_addr == ADDR_W'(i));
    end

    always_comb begin
        ctrl_regs_o = '0;
        for (int i = 0; i < NUM_CTRL; i++)
            ctrl_regs_o[i*DATA_W +: DATA_W] = ctrl_q[i];
    end

    // Sampled in RESP so a write committed during the wait is visible.
    always_comb begin
        rsp_data = UNMAP_DATA;
        for (int i = 0; i < NUM_CTRL; i++)
            if (raddr == ADDR_W'(i))
                rsp_data = ctrl_q[i];
        for (int j = 0; j < NUM_STAT; j++)
            if (raddr == ADDR_W'(NUM_CTRL + j))
                rsp_data = stat_regs_i[j*DATA_W +: DATA_W];
`ifdef SYN_LB_SLAVE_ERR_EN
        if (raddr == ERR_ADDR)
            rsp_data = DATA_W'(err);
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        raddr_n = raddr;
        valid_n = 1'b0;
        data_n  = lb.lb_rd_data;
        unique case (state)
            IDLE: begin
                if (lb.lb_rd_en) begin
                    raddr_n = lb.lb_addr;
                    cnt_n   = CNT_INIT;
                    state_n = (RD_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_n = RESP;
            end
            RESP: begin
                valid_n = 1'b1;
                data_n  = rsp_data;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state          <= IDLE;
            cnt            <= '0;
            raddr          <= '0;
            busy_o         <= 1'b0;
            lb.lb_rd_valid <= 1'b0;
            lb.lb_rd_data  <= '0;
            ctrl_wr_o      <= '0;
            for (int i = 0; i < NUM_CTRL; i++)
                ctrl_q[i] <= CTRL_RST;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            raddr          <= raddr_n;
            busy_o         <= busy_n;
            lb.lb_rd_valid <= valid_n;
            lb.lb_rd_data  <= data_n;
            ctrl_wr_o      <= wr_hit;
            for (int i = 0; i < NUM_CTRL; i++)
                if (wr_hit[i])
                    ctrl_q[i] <= lb.lb_wr_data;
        end
    end
endmodule

// File: tb/tb_syn_lb_reg_slave.sv
// tb_syn_lb_reg_slave.sv: three slaves (RD_LAT 2, 1, 7) share one stimulus stream and
// are compared every cycle against a transaction-level register model.
module tb_syn_lb_reg_slave;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 4;
    localparam int NS = 4;
    localparam int NI = 3;
    localparam int LAT [NI] = '{2, 1, 7};
`ifdef SYN_LB_SLAVE_ERR_EN
    localparam int            NMAP   = NC + NS + 1;
    localparam logic [DW-1:0] UNMAP  = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] ERR_DROP = 32'h4;
    localparam logic [DW-1:0] ERR_UNM  = 32'h3;
`else
    localparam int            NMAP   = NC + NS;
    localparam logic [DW-1:0] UNMAP  = '0;
    localparam logic [DW-1:0] ERR_DROP = '0;
    localparam logic [DW-1:0] ERR_UNM  = '0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] stat [NS];
    logic [NS*DW-1:0] stat_flat;

    logic             o_rv   [NI];
    logic [DW-1:0]    o_rd   [NI];
    logic             o_busy [NI];
    logic [NC-1:0]    o_wr   [NI];
    logic [NC*DW-1:0] o_ctrl [NI];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        stat_flat = '0;
        for (int j = 0; j < NS; j++)
            stat_flat[j*DW +: DW] = stat[j];
    end

    for (genvar k = 0; k < NI; k++) begin : g
        syn_lb_reg_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.lb_rd_en    = rd_en;
        assign bus.lb_wr_en    = wr_en;
        assign bus.lb_addr     = addr;
        assign bus.lb_wr_valid = wr_valid;
        assign bus.lb_wr_data  = wdata;
        assign o_rv[k] = bus.lb_rd_valid;
        assign o_rd[k] = bus.lb_rd_data;
        syn_lb_reg_slave #(
            .DATA_W(DW), .ADDR_W(AW), .NUM_CTRL(NC), .NUM_STAT(NS),
            .RD_LAT(LAT[k]), .CTRL_RST(32'h0)
        ) dut (
            .clk_ir(clk), .rst_il(rst_n), .lb(bus.slave),
            .ctrl_regs_o(o_ctrl[k]), .ctrl_wr_o(o_wr[k]),
            .stat_regs_i(stat_flat), .busy_o(o_busy[k])
        );
    end

    task automatic chk(input string nm, input logic [NC*DW-1:0] act,
                       input logic [NC*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: each accepted read is scheduled LAT edges ahead.
    logic [DW-1:0]    m_ctrl [NC];
    bit               m_pend [NI];
    int               m_due  [NI];
    logic [AW-1:0]    m_addr [NI];
    bit               m_rv   [NI];
    logic [DW-1:0]    m_rd   [NI];
    logic [2:0]       m_err  [NI];
    logic [NC-1:0]    m_wr;
    logic [NC*DW-1:0] m_flat;
    int  cyc = 0;
    bit  wgo, was, clr;
    logic [2:0] ev;

    function automatic logic [DW-1:0] m_lookup(input int k, input logic [AW-1:0] a);
        int ia;
        ia = int'(a);
        if (ia < NC) return m_ctrl[ia];
        if (ia < NC + NS) return stat[ia - NC];
        if (NMAP > NC + NS && ia == NC + NS) return DW'(m_err[k]);
        return UNMAP;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_pend[k] = 0;
                m_rv[k]   = 0;
                m_rd[k]   = '0;
                m_err[k]  = '0;
            end
            for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
            m_wr = '0;
        end else begin
            cyc++;
            wgo = wr_en && wr_valid;
            for (int k = 0; k < NI; k++) begin
                was = m_pend[k];
                clr = 0;
                ev = '0;
                m_rv[k] = 0;
                if (m_pend[k] && m_due[k] == cyc) begin
                    m_rv[k] = 1;
                    m_rd[k] = m_lookup(k, m_addr[k]);
                    m_pend[k] = 0;
                    clr = (int'(m_addr[k]) == NC + NS);
                end
                if (wgo && int'(addr) >= NMAP) ev[0] = 1'b1;
                if (rd_en && was) ev[2] = 1'b1;
                else if (rd_en) begin
                    m_pend[k] = 1;
                    m_due[k]  = cyc + LAT[k];
                    m_addr[k] = addr;
                    if (int'(addr) >= NMAP) ev[1] = 1'b1;
                end
                if (NMAP > NC + NS)
                    m_err[k] = (clr ? 3'b000 : m_err[k]) | ev;
            end
            m_wr = '0;
            if (wgo && int'(addr) < NC) begin
                m_ctrl[int'(addr)] = wdata;
                m_wr[int'(addr)] = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < NC; i++) m_flat[i*DW +: DW] = m_ctrl[i];
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rd_valid[%0d]", k), o_rv[k], m_rv[k]);
                chk($sformatf("busy[%0d]", k), o_busy[k], m_pend[k]);
                chk($sformatf("ctrl_wr[%0d]", k), o_wr[k], m_wr);
                chk($sformatf("ctrl_regs[%0d]", k), o_ctrl[k], m_flat);
                if (m_rv[k])
                    chk($sformatf("rd_data[%0d]", k), o_rd[k], m_rd[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit v);
        wr_en = 1'b1;
        wr_valid = v;
        addr = a;
        wdata = d;
        step();
        wr_en = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic rd_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input bit two, input string nm);
        int seen [NI];
        int when [NI];
        logic [DW-1:0] got [NI];
        for (int k = 0; k < NI; k++) begin
            seen[k] = 0;
            when[k] = -1;
            got[k]  = '0;
        end
        rd_en = 1'b1;
        addr = a;
        for (int n = 0; n < 10; n++) begin
            step();
            if (n == 0 && two) addr = a + 8'd1;
            else rd_en = 1'b0;
            wr_en = 1'b0;
            wr_valid = 1'b0;
            for (int k = 0; k < NI; k++)
                if (o_rv[k]) begin
                    seen[k]++;
                    if (seen[k] == 1) begin
                        when[k] = n;
                        got[k]  = o_rd[k];
                    end
                end
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_pulses[%0d]", nm, k), seen[k], 1);
            chk($sformatf("%s_latency[%0d]", nm, k), when[k], LAT[k]);
            chk($sformatf("%s_data[%0d]", nm, k), got[k], exp);
        end
    endtask

    initial begin
        int stray [NI];
        stat[0] = 32'h0BAD_0000;
        stat[1] = 32'h1234_5678;
        stat[2] = 32'h5555_AAAA;
        stat[3] = 32'h7777_0007;
        rst_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            chk("reset_rd_valid", o_rv[k], 1'b0);
            chk("reset_rd_data", o_rd[k], 32'h0);
            chk("reset_busy", o_busy[k], 1'b0);
            chk("reset_ctrl_wr", o_wr[k], 4'b0000);
            chk("reset_ctrl_regs", o_ctrl[k], 128'h0);
        end
        rst_n = 1'b1;
        step();

        wr(8'd2, 32'hA5A5_0003, 1'b1);
        for (int k = 0; k < NI; k++) begin
            chk("wr_pulse", o_wr[k], 4'b0100);
            chk("wr_value", o_ctrl[k][95:64], 32'hA5A5_0003);
        end
        step();
        for (int k = 0; k < NI; k++) chk("wr_pulse_end", o_wr[k], 4'b0000);
        rd_lit(8'd2, 32'hA5A5_0003, 1'b0, "rd_ctrl2");
        rd_lit(8'd5, 32'h1234_5678, 1'b0, "rd_stat1");
        rd_lit(8'd7, 32'h7777_0007, 1'b0, "rd_stat3");
        wr(8'd3, 32'h0000_0033, 1'b1);
        rd_lit(8'd3, 32'h0000_0033, 1'b0, "rd_ctrl3");

        wr(8'd4, 32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < NI; k++) chk("stat_wr_dropped", o_wr[k], 4'b0000);
        rd_lit(8'd4, 32'h0BAD_0000, 1'b0, "rd_stat0");

        wr(8'd0, 32'h0000_1000, 1'b1);
        wr(8'd1, 32'h1111_1111, 1'b1);
        rd_lit(8'd0, 32'h0000_1000, 1'b1, "busy_drop");

        wr_en = 1'b1;
        wr_valid = 1'b1;
        wdata = 32'h0000_CAFE;
        rd_lit(8'd0, 32'h0000_CAFE, 1'b0, "rd_wr_same");
        wr(8'd0, 32'h0000_BEEF, 1'b0);
        for (int k = 0; k < NI; k++) chk("wr_no_valid", o_wr[k], 4'b0000);
        rd_lit(8'd0, 32'h0000_CAFE, 1'b0, "rd_after_novalid");

        rd_lit(8'd8, ERR_DROP, 1'b0, "err_drop");
        wr(8'hF0, 32'h0000_1234, 1'b1);
        for (int k = 0; k < NI; k++) chk("unmapped_wr", o_wr[k], 4'b0000);
        rd_lit(8'hF0, UNMAP, 1'b0, "rd_unmapped");
        rd_lit(8'd8, ERR_UNM, 1'b0, "err_unmapped");
        rd_lit(8'd8, 32'h0, 1'b0, "err_cleared");
        rd_lit(8'h82, UNMAP, 1'b0, "rd_no_alias");

        rd_en = 1'b1;
        addr = 8'd2;
        step();
        rd_en = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("midrd_rst_valid", o_rv[k], 1'b0);
            chk("midrd_rst_busy", o_busy[k], 1'b0);
            chk("midrd_rst_ctrl", o_ctrl[k], 128'h0);
            stray[k] = 0;
        end
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            for (int k = 0; k < NI; k++) if (o_rv[k]) stray[k]++;
        end
        for (int k = 0; k < NI; k++) chk("no_stray_valid", stray[k], 0);
        rd_lit(8'd2, 32'h0, 1'b0, "rd_after_reset");

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
